sprite_loader: RTL and testbench

- Upstream feeder for the sprite shift register. It accepts sprite bitmap bytes over a valid/ready stream and serialises them into the register through its shift, load and data_in inputs.
- Shifting happens only during vertical blanking, so the display path never contends for the shift enable.
- The top level ORs shift_o with the display-side shift enable. load_o and data_o connect directly to the register.

---
 rtl/sprite_pkg.sv | 18 +
 rtl/sprite_loader_byte_serializer.sv | 35 +++
 rtl/sprite_loader.sv | 117 +++++++++++
 tb/tb_sprite_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and sizing helpers for the sprite upload path.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH  = 12;
  localparam int DEF_HEIGHT = 12;

  function automatic int calc_nbytes(input int nbits);
    return (nbits + 7) / 8;
  endfunction

endpackage

// File: rtl/sprite_loader_byte_serializer.sv
// Parallel-in, LSB-first serial-out byte holder with a per-byte bit count.
module byte_serializer
  import sprite_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] data,
  input  logic [3:0] count,
  input  logic       advance,
  output logic       bit_out,
  output logic       last
);

  logic [7:0] hold_reg;
  logic [3:0] left_reg;

  // advance doubles as the stall input: nothing moves while it is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg <= 8'd0;
      left_reg <= 4'd0;
    end else if (load) begin
      hold_reg <= data;
      left_reg <= count;
    end else if (advance && (left_reg != 4'd0)) begin
      hold_reg <= {1'b0, hold_reg[7:1]};
      left_reg <= left_reg - 4'd1;
    end
  end

  assign bit_out = hold_reg[0];
  assign last    = (left_reg == 4'd1);

endmodule

// File: rtl/sprite_loader.sv
// Streams sprite bitmap bytes into the sprite shift register during vertical blanking.
module sprite_loader
  import sprite_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       vblank,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       shift_o,
  output logic       load_o,
  output logic       data_o,
  output logic       busy,
  output logic       done
);

  localparam int NBITS     = WIDTH * HEIGHT;
  localparam int NBYTES    = calc_nbytes(NBITS);
  localparam int LAST_BITS = NBITS - 8 * (NBYTES - 1);
  localparam int CNT_W     = $clog2(NBITS + 1);
  localparam int IDX_W     = $clog2(NBYTES + 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] bits_done_reg, bits_done_next;
  logic [IDX_W-1:0] byte_idx_reg, byte_idx_next;
  logic [3:0]       byte_bits;
  logic             ser_load;
  logic             ser_advance;
  logic             ser_bit;
  logic             ser_last;

  // Only the final byte can be short; its unused upper bits are never shifted.
  assign byte_bits = (byte_idx_reg == IDX_W'(NBYTES - 1)) ? 4'(LAST_BITS) : 4'd8;

  byte_serializer u_serializer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (ser_load),
    .data    (byte_in),
    .count   (byte_bits),
    .advance (ser_advance),
    .bit_out (ser_bit),
    .last    (ser_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      bits_done_reg <= '0;
      byte_idx_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      bits_done_reg <= bits_done_next;
      byte_idx_reg  <= byte_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bits_done_next = bits_done_reg;
    byte_idx_next  = byte_idx_reg;
    byte_ready     = 1'b0;
    shift_o        = 1'b0;
    load_o         = 1'b0;
    data_o         = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    ser_load       = 1'b0;
    ser_advance    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) state_next = FETCH;
      end

      FETCH: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (byte_valid) begin
          ser_load      = 1'b1;
          byte_idx_next = byte_idx_reg + 1'b1;
          state_next    = SHIFT;
        end
      end

      SHIFT: begin
        busy = 1'b1;
        // Outside blanking the display owns the register, so everything holds.
        if (vblank) begin
          shift_o        = 1'b1;
          load_o         = 1'b1;
          data_o         = ser_bit;
          ser_advance    = 1'b1;
          bits_done_next = bits_done_reg + 1'b1;
          if (ser_last) begin
            state_next = (bits_done_next == CNT_W'(NBITS)) ? DONE : FETCH;
          end
        end
      end

      DONE: begin
        done           = 1'b1;
        bits_done_next = '0;
        byte_idx_next  = '0;
        state_next     = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sprite_loader.sv
// Randomised bench for sprite_loader with a behavioural sprite-image model.
module tb_sprite_loader;

  localparam int NBITS  = 144;
  localparam int NBYTES = 18;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       vblank = 1'b0;
  logic [7:0] byte_in = 8'd0;
  logic       byte_valid = 1'b0;
  logic       byte_ready, shift_o, load_o, data_o, busy, done;

  int errors = 0;
  int checks = 0;

  int cycle = 0;
  int accepted = 0;
  int shifts = 0;
  int done_count = 0;
  int up_shift0 = 0;

  logic [7:0]       cur_data [NBYTES];
  logic [NBITS-1:0] sprite_reg = '0;

  always #5 clk = ~clk;

  sprite_loader #(.WIDTH(12), .HEIGHT(12)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .vblank     (vblank),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .shift_o    (shift_o),
    .load_o     (load_o),
    .data_o     (data_o),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input logic [NBITS-1:0] act, input logic [NBITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pixel k of the sprite is bit k%8 of byte k/8.
  function automatic logic [NBITS-1:0] expected_image();
    logic [NBITS-1:0] img;
    for (int k = 0; k < NBITS; k++) img[k] = cur_data[k / 8][k % 8];
    return img;
  endfunction

  // Monitor: the sprite register fed by the loader, plus event counters.
  initial forever begin
    @(posedge clk);
    cycle++;
    if (reset_n) begin
      if (byte_valid && byte_ready) accepted++;
      if (shift_o) begin
        sprite_reg = load_o ? {data_o, sprite_reg[NBITS-1:1]} : {sprite_reg[0], sprite_reg[NBITS-1:1]};
        shifts++;
      end
      if (done) done_count++;
    end
  end

  // Per-cycle compare against the model's rules.
  initial begin : compare
    int k;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("reset_outputs", int'({byte_ready, shift_o, load_o, data_o, busy, done}), 0);
      end else begin
        chk("load_with_shift", int'(load_o), int'(shift_o));
        if (!vblank) chk("no_shift_outside_vblank", int'(shift_o), 0);
        if (byte_ready) chk("ready_implies_busy", int'(busy), 1);
        if (done) chk("busy_low_at_done", int'(busy), 0);
        if (shift_o) begin
          k = shifts - up_shift0;
          if (k >= NBITS) chk("shift_overrun", k, NBITS - 1);
          else chk($sformatf("data_bit_%0d", k), int'(data_o), int'(cur_data[k / 8][k % 8]));
        end
      end
    end
  end

  // vmode: 0 vblank always high, 1 toggles 10/10 cycles, 2 random.
  task automatic upload(input int vmode, input bit gaps, input int restart_at, input int abort_at);
    int acc0, dn0, t_acc, t_done, got;
    bit pulsed, aborted;
    acc0 = accepted; dn0 = done_count; up_shift0 = shifts;
    t_acc = -1; t_done = -1; pulsed = 1'b0; aborted = 1'b0;
    vblank = 1'b1;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      got = accepted - acc0;
      if (got < NBYTES) begin
        byte_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        byte_in    = cur_data[got];
      end else begin
        byte_valid = 1'b0;
      end
      case (vmode)
        0:       vblank = 1'b1;
        1:       vblank = ((n / 10) % 2 == 0);
        default: vblank = ($urandom_range(0, 3) != 0);
      endcase
      start = 1'b0;
      if (restart_at >= 0 && !pulsed && got == restart_at) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      @(posedge clk); #1;
      if (t_acc < 0 && accepted > acc0) t_acc = cycle;
      if (done_count != dn0) begin
        t_done = cycle;
        break;
      end
      if (abort_at >= 0 && (shifts - up_shift0) == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({byte_ready, shift_o, load_o, data_o, busy, done}), 0);
        aborted = 1'b1;
        break;
      end
    end
    start = 1'b0;
    byte_valid = 1'b0;
    if (aborted) begin
      chk("no_done_on_abort", done_count - dn0, 0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      return;
    end
    chk("done_seen", int'(t_done >= 0), 1);
    // A byte offered after completion must not be consumed.
    byte_valid = 1'b1;
    byte_in = 8'hA5;
    repeat (6) @(posedge clk);
    #1 byte_valid = 1'b0;
    chk("bytes_accepted", accepted - acc0, NBYTES);
    chk("done_pulses", done_count - dn0, 1);
    chk("shift_cycles", shifts - up_shift0, NBITS);
    chk_img("sprite_image", sprite_reg, expected_image());
    if (vmode == 0 && !gaps && t_done >= 0) chk("upload_latency", t_done - t_acc, 162);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NBITS-1:0] saved;
    logic [NBITS-1:0] img;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_init", int'({byte_ready, shift_o, load_o, data_o, busy, done}), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      byte_valid = 1'b1;
      byte_in    = 8'($urandom);
      vblank     = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("idle_outputs", int'({byte_ready, shift_o, load_o, data_o, busy, done}), 0);
    end
    byte_valid = 1'b0;
    chk("idle_no_accept", accepted, 0);

    for (int i = 0; i < NBYTES; i++) cur_data[i] = 8'(i + 1);
    img = expected_image();
    chk("model_pin_byte1", int'(img[15:8]), 2);
    upload(0, 1'b0, -1, -1);
    chk("pin_bit0", int'(sprite_reg[0]), 1);
    chk("pin_bit1", int'(sprite_reg[1]), 0);
    chk("pin_bit9", int'(sprite_reg[9]), 1);
    chk("pin_bit17", int'(sprite_reg[17]), 1);
    chk("pin_low_byte", int'(sprite_reg[7:0]), 'h01);
    chk("pin_top_byte", int'(sprite_reg[143:136]), 'h12);
    saved = sprite_reg;

    sprite_reg = '0;
    upload(1, 1'b0, -1, -1);
    chk_img("paused_matches_unpaused", sprite_reg, saved);

    for (int i = 0; i < NBYTES; i++) cur_data[i] = 8'hFF;
    upload(0, 1'b0, -1, -1);
    chk_img("all_ones", sprite_reg, {NBITS{1'b1}});

    for (int i = 0; i < NBYTES; i++) cur_data[i] = 8'($urandom);
    upload(2, 1'b1, 5, -1);

    for (int i = 0; i < NBYTES; i++) cur_data[i] = 8'($urandom);
    upload(0, 1'b0, -1, 70);

    for (int i = 0; i < NBYTES; i++) cur_data[i] = 8'($urandom);
    upload(2, 1'b1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
